// File: rtl/ex_mdu_ctrl.sv
// Sequencer for the multi-cycle EX operations: two-cycle multiply-accumulate and
// iterative DIV/DIVU with start/ready handshake, flush annul and divider watchdog.
module ex_mdu_ctrl #(
  parameter int DATA_W         = 32,
  parameter int DIV_MAX_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mc_op_i,
  input  logic                  flush_i,
  input  logic                  pipe_hold_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic [2*DATA_W-1:0]   ex_hilo_temp_i,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [1:0]            cnt_o,
  output logic                  stallreq_o,
  output logic                  div_start_o,
  output logic                  div_signed_o,
  output logic [DATA_W-1:0]     div_opdata1_o,
  output logic [DATA_W-1:0]     div_opdata2_o,
  output logic                  div_annul_o,
  input  logic [2*DATA_W-1:0]   div_result_i,
  input  logic                  div_ready_i,
  output logic [2*DATA_W-1:0]   div_result_o,
  output logic                  div_done_o,
  output logic                  div_err_o
);

  typedef enum logic [1:0] {IDLE, MAC_ACC, DIV_RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] wd_cnt;
  logic             accept;
  logic             wd_expire;

  assign accept    = (state == IDLE) && (mc_op_i != 2'b00) && !pipe_hold_i && !flush_i;
  assign wd_expire = (wd_cnt == CNT_W'(DIV_MAX_CYCLES - 1));

  // Stall is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    stallreq_o = 1'b0;
    if (rst && !flush_i) begin
      case (state)
        IDLE:    stallreq_o = accept;
        DIV_RUN: stallreq_o = 1'b1;
        default: stallreq_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      wd_cnt        <= '0;
      hilo_temp_o   <= '0;
      cnt_o         <= 2'b00;
      div_start_o   <= 1'b0;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
      div_annul_o   <= 1'b0;
      div_result_o  <= '0;
      div_done_o    <= 1'b0;
      div_err_o     <= 1'b0;
    end else begin
      div_annul_o <= 1'b0;
      if (flush_i) begin
        state        <= IDLE;
        hilo_temp_o  <= '0;
        cnt_o        <= 2'b00;
        div_result_o <= '0;
        div_start_o  <= 1'b0;
        div_done_o   <= 1'b0;
        if (state == DIV_RUN) div_annul_o <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (mc_op_i == 2'b01) begin
                hilo_temp_o <= ex_hilo_temp_i;
                cnt_o       <= 2'b01;
                state       <= MAC_ACC;
              end else if (opdata2_i != '0) begin
                div_opdata1_o <= opdata1_i;
                div_opdata2_o <= opdata2_i;
                div_signed_o  <= ~mc_op_i[0];
                wd_cnt        <= '0;
                div_start_o   <= 1'b1;
                state         <= DIV_RUN;
              end else begin
                // Divide by zero completes immediately without touching the divider.
                div_result_o <= '0;
                div_done_o   <= 1'b1;
                state        <= DONE;
              end
            end
          end
          MAC_ACC: begin
            if (!pipe_hold_i) begin
              hilo_temp_o <= '0;
              cnt_o       <= 2'b00;
              state       <= IDLE;
            end
          end
          DIV_RUN: begin
            if (div_ready_i) begin
              div_result_o <= div_result_i;
              div_start_o  <= 1'b0;
              div_done_o   <= 1'b1;
              state        <= DONE;
            end else if (wd_expire) begin
              div_annul_o  <= 1'b1;
              div_result_o <= '0;
              div_err_o    <= 1'b1;
              div_start_o  <= 1'b0;
              div_done_o   <= 1'b1;
              state        <= DONE;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
          DONE: begin
            if (!pipe_hold_i) begin
              div_done_o <= 1'b0;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
